dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the mips core and one external requester (program loader / DMA / debug).
- The core is single-cycle and touches memory every enabled cycle, so the arbiter stalls it by deasserting its enable whenever the external requester owns the port.
- Sits at top level between mips (mem_wr/mem_addr/mem_writedata/mem_readdata, enable) and the data memory.
- A burst limit forces one core cycle so neither side starves.

---
 rtl/dmem_arbiter.sv | 72 +++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the mips core and one external requester
// Ports:
//   clk, reset (sync, active-low), enable_in (global run enable)
//   cpu_enable / cpu_mem_* : core side; the core is stalled while the external side owns the port
//   ext_req/ext_wr/ext_addr/ext_wdata -> ext_gnt, ext_rdata, ext_rvalid : external requester
//   mem_wr/mem_addr/mem_writedata/mem_readdata : data memory port
//   arb_state : 00 CPU, 01 EXT, 10 YIELD
module dmem_arbiter #(
    parameter int Abits     = 32,
    parameter int Dbits     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_in,
    output logic             cpu_enable,
    input  logic             cpu_mem_wr,
    input  logic [Abits-1:0] cpu_mem_addr,
    input  logic [Dbits-1:0] cpu_mem_writedata,
    output logic [Dbits-1:0] cpu_mem_readdata,
    input  logic             ext_req,
    input  logic             ext_wr,
    input  logic [Abits-1:0] ext_addr,
    input  logic [Dbits-1:0] ext_wdata,
    output logic             ext_gnt,
    output logic [Dbits-1:0] ext_rdata,
    output logic             ext_rvalid,
    output logic             mem_wr,
    output logic [Abits-1:0] mem_addr,
    output logic [Dbits-1:0] mem_writedata,
    input  logic [Dbits-1:0] mem_readdata,
    output logic [1:0]       arb_state
);
    typedef enum logic [1:0] {CPU = 2'b00, EXT = 2'b01, YIELD = 2'b10} state_t;
    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       xfer, last;
    assign ext_gnt          = state == EXT;
    assign xfer             = ext_req & ext_gnt;
    assign last             = cnt == 8'(MAX_BURST - 1);
    assign arb_state        = state;
    assign cpu_mem_readdata = mem_readdata;
    assign mem_addr         = ext_gnt ? ext_addr : cpu_mem_addr;
    assign mem_writedata    = ext_gnt ? ext_wdata : cpu_mem_writedata;
    // reset low overrides both strobes so nothing is written while held in reset
    assign mem_wr           = reset & (ext_gnt ? ext_wr & ext_req : cpu_mem_wr & enable_in);
    assign cpu_enable       = reset & ~ext_gnt & enable_in;
    always_comb begin
        state_next = CPU;
        // counter only advances across consecutive transfers inside one grant; every other path restarts it
        cnt_next   = (xfer && !last) ? cnt + 8'd1 : 8'd0;
        case (state)
            CPU:     state_next = ext_req ? EXT : CPU;
            EXT:     state_next = !ext_req ? CPU : (last ? YIELD : EXT);
            YIELD:   state_next = ext_req ? EXT : CPU;
            default: state_next = CPU;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= CPU;
            cnt        <= 8'd0;
            ext_rdata  <= '0;
            ext_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ext_rvalid <= xfer & ~ext_wr;
            if (xfer && !ext_wr) ext_rdata <= mem_readdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, corner sequences and randomized model check for dmem_arbiter
module tb_dmem_arbiter;
    localparam int MAXB = 8;
    logic        clk = 1'b0;
    logic        reset, enable_in, cpu_enable, cpu_mem_wr, ext_req, ext_wr, ext_gnt, ext_rvalid, mem_wr;
    logic [31:0] cpu_mem_addr, cpu_mem_writedata, cpu_mem_readdata, ext_addr, ext_wdata, ext_rdata;
    logic [31:0] mem_addr, mem_writedata, mem_readdata;
    logic [1:0]  arb_state;
    always #5 clk = ~clk;

    dmem_arbiter #(.Abits(32), .Dbits(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .enable_in(enable_in), .cpu_enable(cpu_enable),
        .cpu_mem_wr(cpu_mem_wr), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_writedata(cpu_mem_writedata),
        .cpu_mem_readdata(cpu_mem_readdata), .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .arb_state(arb_state)
    );

    logic [31:0] tb_mem [256] = '{8: 32'h1234, 9: 32'h5678, 10: 32'h9abc, default: 32'h0};
    logic [31:0] ref_mem [256];
    assign mem_readdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) tb_mem[mem_addr[9:2]] <= mem_writedata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic cw, input logic [31:0] ca,
                         input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
        reset = r; enable_in = e; cpu_mem_wr = cw; cpu_mem_addr = ca;
        ext_req = rq; ext_wr = w; ext_addr = a; ext_wdata = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r, e, cw; logic [31:0] ca; logic rq, w; logic [31:0] a, d;
        logic [1:0] st; logic gnt, cen, mwr; logic [31:0] maddr; logic rv; logic [31:0] rd;
    } vec_t;
    vec_t tbl [21];

    function automatic vec_t mk(logic r, logic e, logic cw, logic [31:0] ca, logic rq, logic w,
                                logic [31:0] a, logic [31:0] d, logic [1:0] st, logic gnt, logic cen,
                                logic mwr, logic [31:0] maddr, logic rv, logic [31:0] rd);
        vec_t v;
        v.r = r; v.e = e; v.cw = cw; v.ca = ca; v.rq = rq; v.w = w; v.a = a; v.d = d;
        v.st = st; v.gnt = gnt; v.cen = cen; v.mwr = mwr; v.maddr = maddr; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    // behavioural model: who owns the port, transfers in the current grant, pending read return
    bit          m_gnt, m_yield, m_rv;
    int          m_xfers;
    logic [31:0] m_rd;

    initial begin
        int          run;
        logic [1:0]  est;
        logic        prev_ext, r_req, last_x, x, e_mwr, ng, ny;
        logic [31:0] r_a, r_d;
        int          diff;
        drive(0, 1, 1, 32'h40, 0, 0, 0, 0);
        tick;
        // reset / idle, single external write, external reads, halted-core loader
        tbl[0]  = mk(0,1,1,32'h40, 0,0,32'h00,32'h0,         2'd0,0,0,0,32'h40, 0,32'h0);
        tbl[1]  = mk(0,1,1,32'h40, 0,0,32'h00,32'h0,         2'd0,0,0,0,32'h40, 0,32'h0);
        tbl[2]  = mk(0,1,1,32'h40, 0,0,32'h00,32'h0,         2'd0,0,0,0,32'h40, 0,32'h0);
        tbl[3]  = mk(1,1,0,32'h40, 0,0,32'h00,32'h0,         2'd0,0,1,0,32'h40, 0,32'h0);
        tbl[4]  = mk(1,1,0,32'h40, 1,1,32'h10,32'hDEADBEEF,  2'd0,0,1,0,32'h40, 0,32'h0);
        tbl[5]  = mk(1,1,0,32'h40, 1,1,32'h10,32'hDEADBEEF,  2'd1,1,0,1,32'h10, 0,32'h0);
        tbl[6]  = mk(1,1,0,32'h40, 0,1,32'h10,32'hDEADBEEF,  2'd1,1,0,0,32'h10, 0,32'h0);
        tbl[7]  = mk(1,1,0,32'h40, 0,0,32'h10,32'h0,         2'd0,0,1,0,32'h40, 0,32'h0);
        tbl[8]  = mk(1,1,0,32'h40, 1,0,32'h20,32'h0,         2'd0,0,1,0,32'h40, 0,32'h0);
        tbl[9]  = mk(1,1,0,32'h40, 1,0,32'h20,32'h0,         2'd1,1,0,0,32'h20, 0,32'h0);
        tbl[10] = mk(1,1,0,32'h40, 1,0,32'h24,32'h0,         2'd1,1,0,0,32'h24, 1,32'h1234);
        tbl[11] = mk(1,1,0,32'h40, 1,0,32'h28,32'h0,         2'd1,1,0,0,32'h28, 1,32'h5678);
        tbl[12] = mk(1,1,0,32'h40, 0,0,32'h28,32'h0,         2'd1,1,0,0,32'h28, 1,32'h9abc);
        tbl[13] = mk(1,1,0,32'h40, 0,0,32'h28,32'h0,         2'd0,0,1,0,32'h40, 0,32'h9abc);
        tbl[14] = mk(1,0,1,32'h40, 1,1,32'h00,32'hA0,        2'd0,0,0,0,32'h40, 0,32'h9abc);
        tbl[15] = mk(1,0,1,32'h40, 1,1,32'h00,32'hA0,        2'd1,1,0,1,32'h00, 0,32'h9abc);
        tbl[16] = mk(1,0,1,32'h40, 1,1,32'h04,32'hA1,        2'd1,1,0,1,32'h04, 0,32'h9abc);
        tbl[17] = mk(1,0,1,32'h40, 1,1,32'h08,32'hA2,        2'd1,1,0,1,32'h08, 0,32'h9abc);
        tbl[18] = mk(1,0,1,32'h40, 1,1,32'h0C,32'hA3,        2'd1,1,0,1,32'h0C, 0,32'h9abc);
        tbl[19] = mk(1,0,1,32'h40, 0,1,32'h0C,32'hA3,        2'd1,1,0,0,32'h0C, 0,32'h9abc);
        tbl[20] = mk(1,0,1,32'h40, 0,0,32'h0C,32'h0,         2'd0,0,0,0,32'h40, 0,32'h9abc);
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].cw, tbl[i].ca, tbl[i].rq, tbl[i].w, tbl[i].a, tbl[i].d);
            #1;
            chk($sformatf("v%0d_state", i), 32'(arb_state), 32'(tbl[i].st));
            chk($sformatf("v%0d_gnt", i), 32'(ext_gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_cpu_en", i), 32'(cpu_enable), 32'(tbl[i].cen));
            chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr), 32'(tbl[i].mwr));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
            chk($sformatf("v%0d_rvalid", i), 32'(ext_rvalid), 32'(tbl[i].rv));
            chk($sformatf("v%0d_rdata", i), ext_rdata, tbl[i].rd);
            if (tbl[i].mwr) chk($sformatf("v%0d_wdata", i), mem_writedata, tbl[i].d);
            tick;
        end
        chk("mem_ext_write", tb_mem[4], 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) chk($sformatf("mem_loader%0d", i), tb_mem[i], 32'hA0 + 32'(i));
        chk("mem_no_core_write", tb_mem[16], 32'h0);

        // burst limit: continuous reads, MAXB transfers then one yield, repeating
        drive(1, 1, 0, 32'h80, 1, 0, 32'h20, 0);
        prev_ext = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            est = (i == 0) ? 2'd0 : (((i - 1) % (MAXB + 1)) < MAXB ? 2'd1 : 2'd2);
            chk($sformatf("burst%0d_state", i), 32'(arb_state), 32'(est));
            chk($sformatf("burst%0d_rvalid", i), 32'(ext_rvalid), 32'(prev_ext));
            if (prev_ext) chk($sformatf("burst%0d_rdata", i), ext_rdata, 32'h1234);
            if (est == 2'd2) begin
                chk($sformatf("burst%0d_yield_cen", i), 32'(cpu_enable), 32'h1);
                chk($sformatf("burst%0d_yield_addr", i), mem_addr, 32'h80);
            end
            prev_ext = (est == 2'd1);
            tick;
        end
        drive(1, 1, 0, 32'h80, 0, 0, 32'h20, 0);
        #1;
        chk("drop_gnt_no_xfer", 32'({ext_gnt, mem_wr}), 32'h2);
        tick;
        #1;
        chk("drop_back_cpu", 32'(arb_state), 32'h0);
        tick;

        // reset in the cycle after a granted read
        drive(1, 1, 0, 32'h80, 1, 0, 32'h24, 0);
        tick;
        tick;
        reset = 0;
        #1;
        chk("rst_mid_rvalid", 32'(ext_rvalid), 32'h1);
        chk("rst_mid_rdata", ext_rdata, 32'h5678);
        chk("rst_mid_cen", 32'(cpu_enable), 32'h0);
        tick;
        #1;
        chk("rst_state", 32'(arb_state), 32'h0);
        chk("rst_gnt", 32'(ext_gnt), 32'h0);
        chk("rst_rvalid", 32'(ext_rvalid), 32'h0);
        reset = 1;
        tick;
        #1;
        chk("rst_regrant", 32'(ext_gnt), 32'h1);
        run = 0;
        for (int k = 0; k < 12; k++) begin
            if (arb_state == 2'b10) break;
            run += int'(ext_gnt);
            tick;
            #1;
        end
        chk("rst_burst_len", 32'(run), 32'(MAXB));
        drive(1, 1, 0, 32'h80, 0, 0, 0, 0);
        tick;
        tick;

        // randomized run against the behavioural model
        reset = 0;
        tick;
        ref_mem = tb_mem;
        m_gnt = 0; m_yield = 0; m_rv = 0; m_xfers = 0; m_rd = 0;
        r_req = 0; last_x = 0; r_a = 0; r_d = 0; ext_wr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!r_req || last_x) begin
                ext_wr = 1'($urandom);
                r_a = $urandom & 32'h3fc;
                r_d = $urandom;
            end
            if ($urandom_range(0, 3) == 0) r_req = ~r_req;
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom & 32'h3fc, r_req, ext_wr, r_a, r_d);
            cpu_mem_writedata = $urandom;
            #1;
            x     = m_gnt && ext_req;
            e_mwr = reset && (m_gnt ? (ext_req && ext_wr) : (cpu_mem_wr && enable_in));
            chk("rnd_state", 32'(arb_state), m_gnt ? 32'h1 : (m_yield ? 32'h2 : 32'h0));
            chk("rnd_gnt", 32'(ext_gnt), 32'(m_gnt));
            chk("rnd_cpu_en", 32'(cpu_enable), 32'(reset && !m_gnt && enable_in));
            chk("rnd_mem_wr", 32'(mem_wr), 32'(e_mwr));
            chk("rnd_mem_addr", mem_addr, m_gnt ? ext_addr : cpu_mem_addr);
            if (e_mwr) chk("rnd_wdata", mem_writedata, m_gnt ? ext_wdata : cpu_mem_writedata);
            chk("rnd_rvalid", 32'(ext_rvalid), 32'(m_rv));
            if (m_rv) chk("rnd_rdata", ext_rdata, m_rd);
            if (!reset) begin
                m_gnt = 0; m_yield = 0; m_rv = 0; m_xfers = 0;
            end else begin
                if (e_mwr) ref_mem[mem_addr[9:2]] = m_gnt ? ext_wdata : cpu_mem_writedata;
                m_rv = x && !ext_wr;
                if (m_rv) m_rd = ref_mem[ext_addr[9:2]];
                ny = x && (m_xfers + 1 == MAXB);
                ng = ext_req && !ny;
                m_xfers = (m_gnt && ng) ? m_xfers + 1 : 0;
                m_gnt = ng;
                m_yield = ny;
            end
            last_x = x;
            tick;
        end
        diff = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
        chk("rnd_mem_image", 32'(diff), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
